// File: rtl/accum_quantize_pkg.sv
// Shared int8 requantization helpers for the accumulate, pooling and ReLU stages.
package accum_quantize_pkg;

   localparam logic signed [7:0] INT8_MIN = -8'sd128;
   localparam logic signed [7:0] INT8_MAX = 8'sd127;

   typedef struct packed {
      logic signed [7:0] value;
      logic              sat;
   } sat8_t;

   // Clamp a wide signed value into int8 and report whether the clamp engaged.
   function automatic sat8_t sat8(input logic signed [63:0] x);
      sat8_t r;
      if (x > 64'(INT8_MAX)) begin
         r.value = INT8_MAX;
         r.sat   = 1'b1;
      end else if (x < 64'(INT8_MIN)) begin
         r.value = INT8_MIN;
         r.sat   = 1'b1;
      end else begin
         r.value = x[7:0];
         r.sat   = 1'b0;
      end
      return r;
   endfunction

   // Round half up, then arithmetic right shift.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                      input int unsigned    shift);
      return (x + (64'sd1 <<< (shift - 1))) >>> shift;
   endfunction

endpackage

// File: rtl/accum_quantize_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head entry is visible while not empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Gate the head so out_data reads 0 rather than stale storage when empty.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/accum_quantize.sv
// Accumulates NUM_PASSES partial sums plus bias, requantizes to int8 and buffers results.
module accum_quantize
   import accum_quantize_pkg::*;
#(
   parameter int NUM_PASSES = 9,
   parameter int ACC_WIDTH  = 40,
   parameter int SHIFT      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] in_data,
   input  logic signed [31:0] bias,
   input  logic               relu_en,
   input  logic               group_clear,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [7:0]  out_data,
   output logic               sat_flag
);

   localparam int CNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
   localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W = FCW + 1;
   localparam logic signed [ACC_WIDTH:0] ROUND = (ACC_WIDTH+1)'(1) << (SHIFT - 1);

   logic [CNT_W-1:0]            pass_cnt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic signed [ACC_WIDTH-1:0] data_ext;
   logic signed [ACC_WIDTH-1:0] bias_ext;
   logic                        accept;
   logic                        last_beat;

   logic                        q1_v;
   logic signed [ACC_WIDTH:0]   q1;
   logic                        q1_relu;
   logic signed [ACC_WIDTH:0]   shifted;
   logic signed [ACC_WIDTH:0]   relu_val;
   sat8_t                       q2_next;
   logic                        q2_v;
   logic signed [7:0]           q2;

   logic [FCW-1:0]              fifo_count;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [7:0]                  fifo_data;
   logic [OCC_W-1:0]            occupancy;

   assign data_ext  = {{(ACC_WIDTH-32){in_data[31]}}, in_data};
   assign bias_ext  = {{(ACC_WIDTH-32){bias[31]}}, bias};
   assign last_beat = (pass_cnt == CNT_W'(NUM_PASSES - 1));

   // Results already in Q1/Q2 hold a FIFO slot, so a full FIFO can never be overrun.
   assign occupancy = OCC_W'(fifo_count) + OCC_W'(q1_v) + OCC_W'(q2_v);
   assign in_ready  = !reset && !fifo_full && (occupancy < OCC_W'(FIFO_DEPTH));
   assign accept    = in_valid && in_ready && !group_clear;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      acc_next = acc + data_ext;
      if (pass_cnt == '0) acc_next = bias_ext + data_ext;

      shifted  = q1 >>> SHIFT;
      relu_val = shifted;
      if (q1_relu && shifted[ACC_WIDTH]) relu_val = '0;
      q2_next  = sat8(64'(relu_val));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pass_cnt <= '0;
         acc      <= '0;
         q1_v     <= 1'b0;
         q1       <= '0;
         q1_relu  <= 1'b0;
         q2_v     <= 1'b0;
         q2       <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (group_clear) begin
            pass_cnt <= '0;
            acc      <= '0;
         end else if (accept) begin
            pass_cnt <= last_beat ? '0 : pass_cnt + 1'b1;
            acc      <= last_beat ? '0 : acc_next;
         end

         q1_v <= accept && last_beat;
         if (accept && last_beat) begin
            q1      <= {acc_next[ACC_WIDTH-1], acc_next} + ROUND;
            q1_relu <= relu_en;
         end

         q2_v <= q1_v;
         if (q1_v) begin
            q2 <= q2_next.value;
            if (q2_next.sat) sat_flag <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (q2_v),
      .push_data (q2),
      .pop       (out_ready),
      .pop_data  (fifo_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_data;

endmodule

// File: tb/tb_accum_quantize.sv
// Directed and randomized bench for accum_quantize against an arithmetic reference model.
module tb_accum_quantize;

   localparam int NP = 3;
   localparam int SH = 8;
   localparam int AW = 40;
   localparam int FD = 4;

   logic               clock = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_data;
   logic signed [31:0] bias;
   logic               relu_en;
   logic               group_clear;
   logic               out_valid;
   logic               out_ready;
   logic signed [7:0]  out_data;
   logic               sat_flag;

   int      checks   = 0;
   int      failures = 0;
   int      n_pops   = 0;
   bit      rand_ready = 1'b0;

   int      m_cnt = 0;
   longint  m_sum = 0;
   bit      m_sat = 1'b0;
   longint  exp_q[$];

   always #5 clock = ~clock;

   accum_quantize #(
      .NUM_PASSES (NP),
      .ACC_WIDTH  (AW),
      .SHIFT      (SH),
      .FIFO_DEPTH (FD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .bias        (bias),
      .relu_en     (relu_en),
      .group_clear (group_clear),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .sat_flag    (sat_flag)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Reference: exact sum of bias and partial sums, rounded to nearest (ties up), ReLU, clamp.
   task automatic model_accept(input longint d, input longint b, input bit r);
      real    scaled;
      longint q;
      if (m_cnt == 0) m_sum = b + d;
      else            m_sum = m_sum + d;
      if (m_cnt == NP - 1) begin
         scaled = $floor(real'(m_sum) / (2.0 ** SH) + 0.5);
         q = longint'(scaled);
         if (r && q < 0) q = 0;
         if (q > 127)  begin q = 127;  m_sat = 1'b1; end
         if (q < -128) begin q = -128; m_sat = 1'b1; end
         exp_q.push_back(q);
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
   endtask

   // One clock: score any pop that happens on this edge, then advance to just after it.
   task automatic tick();
      logic signed [63:0] e;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         n_pops++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd999;
         chk("out_data", out_data, e);
      end
      @(posedge clock);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_beat(input int d, input int b, input bit r);
      bit acc_ok = 1'b0;
      int waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      bias     = b;
      relu_en  = r;
      while (!acc_ok && waited < 200) begin
         acc_ok = (in_ready === 1'b1);
         tick();
         waited++;
      end
      in_valid = 1'b0;
      if (!acc_ok) chk("beat_accept_timeout", 0, 1);
      else model_accept(d, b, r);
   endtask

   // Bias only matters on the first beat and relu only on the last; other beats carry junk.
   task automatic send_group(input int d0, input int d1, input int d2, input int b, input bit r);
      send_beat(d0, b, 1'($urandom_range(0, 1)));
      send_beat(d1, int'($urandom_range(0, 9999)) - 5000, 1'($urandom_range(0, 1)));
      send_beat(d2, int'($urandom_range(0, 9999)) - 5000, r);
   endtask

   task automatic send_random_group(input int span);
      send_group(int'($urandom_range(0, 2 * span)) - span,
                 int'($urandom_range(0, 2 * span)) - span,
                 int'($urandom_range(0, 2 * span)) - span,
                 int'($urandom_range(0, 6000)) - 3000,
                 1'($urandom_range(0, 1)));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() > 0 || out_valid === 1'b1) && n < 300) begin
         tick();
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      bias        = '0;
      relu_en     = 1'b0;
      group_clear = 1'b0;
      out_ready   = 1'b1;

      // Reset state
      @(posedge clock); #1;
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sat_flag", sat_flag, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Basic group and latency: 640 >> 8 = 2, visible 3 clocks after the last beat
      send_group(100, 200, 212, 0, 1'b0);
      chk("lat_edge_k", out_valid, 0);
      tick();
      chk("lat_edge_k1", out_valid, 0);
      tick();
      chk("lat_edge_k2", out_valid, 1);
      chk("basic_value", out_data, 2);
      drain();

      // Negative bias with and without ReLU
      send_group(0, 0, 0, -2048, 1'b1);
      send_group(0, 0, 0, -2048, 1'b0);
      drain();
      chk("sat_after_relu", sat_flag, m_sat);

      // Saturation both ways
      send_group(40000, 40000, 40000, 0, 1'b0);
      send_group(-40000, -40000, -40000, 0, 1'b0);
      drain();
      chk("sat_sticky_set", sat_flag, m_sat);

      // Back-pressure: four results fill the reserved capacity
      out_ready = 1'b0;
      for (int g = 0; g < 4; g++) send_random_group(30000);
      tick(); tick(); tick();
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_head_held", out_data, exp_q[0]);
      tick(); tick();
      chk("bp_head_still_held", out_data, exp_q[0]);
      p = n_pops;
      out_ready = 1'b1;
      for (int g = 0; g < 4; g++) send_random_group(30000);
      drain();
      chk("bp_output_count", n_pops - p, 8);

      // group_clear drops the partial group and the beat presented with it
      send_beat(5000, 7000, 1'b0);
      send_beat(6000, 0, 1'b0);
      group_clear = 1'b1;
      in_valid    = 1'b1;
      in_data     = 32'sd90000;
      tick();
      group_clear = 1'b0;
      in_valid    = 1'b0;
      m_cnt = 0;
      p = n_pops;
      send_group(1000, -300, 2000, 500, 1'b0);
      drain();
      chk("clear_single_output", n_pops - p, 1);

      // Randomized traffic with random back-pressure
      rand_ready = 1'b1;
      for (int g = 0; g < 20; g++) send_random_group(60000);
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();
      chk("rand_sat_flag", sat_flag, m_sat);

      // Reset with results in the FIFO and in the pipeline
      out_ready = 1'b0;
      send_random_group(20000);
      tick(); tick(); tick();
      send_random_group(20000);
      reset = 1'b1;
      tick();
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_data", out_data, 0);
      reset = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      m_sat = 1'b0;
      out_ready = 1'b1;
      p = n_pops;
      for (int i = 0; i < 10; i++) tick();
      chk("midrst_no_emit", n_pops - p, 0);
      chk("midrst_sat_clear", sat_flag, m_sat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
